// File: rtl/axi_read_arbiter.sv
// Two-port AXI4 read arbiter: one outstanding burst, AR beat forwarded, R burst steered to winner.
// Define AXI_READ_ARB_RR_EN for round-robin tie-break; otherwise port 0 wins ties.
module axi_read_arbiter #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned AXI_LEN_W  = 8,
    parameter int unsigned AXI_ID_W   = 1,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    // Requester 0 (instruction-cache refill)
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    input  logic [AXI_ADDR_W-1:0] s0_araddr,
    input  logic [AXI_LEN_W-1:0]  s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [1:0]            s0_arburst,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    output logic [AXI_DATA_W-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    // Requester 1 (data-cache refill)
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    input  logic [AXI_ADDR_W-1:0] s1_araddr,
    input  logic [AXI_LEN_W-1:0]  s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [1:0]            s1_arburst,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    output logic [AXI_DATA_W-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    // Shared AXI4 read master
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic [AXI_LEN_W-1:0]  m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [AXI_ID_W-1:0]   m_axi_arid,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [AXI_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
`ifdef AXI_READ_ARB_RR_EN
    logic   last_grant_q, last_grant_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
`ifdef AXI_READ_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
`ifdef AXI_READ_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
`ifdef AXI_READ_ARB_RR_EN
        last_grant_d  = last_grant_q;
`endif
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        s0_arready    = 1'b0;
        s1_arready    = 1'b0;
        s0_rvalid     = 1'b0;
        s1_rvalid     = 1'b0;
        case (state_q)
            StIdle: begin
                if (s0_arvalid || s1_arvalid) begin
                    state_d = StAddr;
`ifdef AXI_READ_ARB_RR_EN
                    if (s0_arvalid && s1_arvalid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = s1_arvalid;
                    end
                    last_grant_d = grant_d;
`else
                    grant_d = ~s0_arvalid;
`endif
                end
            end
            StAddr: begin
                m_axi_arvalid = 1'b1;
                s0_arready    = ~grant_q & m_axi_arready;
                s1_arready    = grant_q & m_axi_arready;
                if (m_axi_arready) begin
                    state_d = StData;
                end
            end
            StData: begin
                // Beats outside DATA are stalled; here the winner alone sees and accepts them.
                s0_rvalid    = ~grant_q & m_axi_rvalid;
                s1_rvalid    = grant_q & m_axi_rvalid;
                m_axi_rready = grant_q ? s1_rready : s0_rready;
                if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign m_axi_araddr  = grant_q ? s1_araddr  : s0_araddr;
    assign m_axi_arlen   = grant_q ? s1_arlen   : s0_arlen;
    assign m_axi_arsize  = grant_q ? s1_arsize  : s0_arsize;
    assign m_axi_arburst = grant_q ? s1_arburst : s0_arburst;
    assign m_axi_arid    = AXI_ID_W'(AXI_ID);
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;

    assign s0_rdata = m_axi_rdata;
    assign s0_rresp = m_axi_rresp;
    assign s0_rlast = m_axi_rlast;
    assign s1_rdata = m_axi_rdata;
    assign s1_rresp = m_axi_rresp;
    assign s1_rlast = m_axi_rlast;

endmodule
